// File: rtl/eth_pkg.sv
// Shared Ethernet/RMII definitions for the transmit serialiser.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        IPG
    } tx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef logic [1:0] dibit_t;

endpackage

// File: rtl/rmii_tx_serializer.sv
// RMII transmit serialiser: wraps upstream payload bytes in preamble/SFD,
// shifts them out as TXD dibits LSB-pair-first and enforces the inter-packet
// gap. Every output is a flop driven from the next-state decode, so the wire
// reflects the state being entered on each edge.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | waiting for axiiv, wire quiet
//  PREAMBLE | PREAMBLE_BYTES x 0x55 on the wire
//  SFD      | 0xD5; byte fetch on its last dibit
//  DATA     | shifting payload byte; fetch on last dibit unless last seen
//  IPG      | IPG_BYTES quiet byte times, input ignored
module rmii_tx_serializer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IPG_BYTES      = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] axiid,
    input  logic       axiiv,
    input  logic       axiilast,
    output logic       axiir,
    output logic [1:0] axiod,
    output logic       axiov,
    output logic       underrun,
    output logic       busy
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] IPG_LAST = 8'(IPG_BYTES - 1);

    tx_state_t  state_q, state_d;
    logic [1:0] dib_q, dib_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] shreg_q, shreg_d;
    logic       last_q, last_d;
    logic       underrun_d;
    dibit_t     axiod_d;
    logic       axiov_d, axiir_d, busy_d;

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dib_q    <= 2'd0;
            byte_q   <= 8'd0;
            shreg_q  <= 8'd0;
            last_q   <= 1'b0;
            axiod    <= 2'b00;
            axiov    <= 1'b0;
            axiir    <= 1'b0;
            underrun <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dib_q    <= dib_d;
            byte_q   <= byte_d;
            shreg_q  <= shreg_d;
            last_q   <= last_d;
            axiod    <= axiod_d;
            axiov    <= axiov_d;
            axiir    <= axiir_d;
            underrun <= underrun_d;
            busy     <= busy_d;
        end
    end

    // Next-state decode and next-cycle output values.
    always_comb begin
        state_d    = state_q;
        dib_d      = dib_q + 2'd1;
        byte_d     = byte_q;
        shreg_d    = {2'b00, shreg_q[7:2]};
        last_d     = last_q;
        underrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                dib_d = 2'd0;
                if (axiiv) begin
                    state_d = PREAMBLE;
                    byte_d  = 8'd0;
                    last_d  = 1'b0;
                end
            end
            PREAMBLE: begin
                if (dib_q == 2'd3) begin
                    if (byte_q == PRE_LAST) begin
                        state_d = SFD;
                        byte_d  = 8'd0;
                    end else begin
                        byte_d = byte_q + 8'd1;
                    end
                end
            end
            SFD, DATA: begin
                // Consumption is tied to the visible ready so upstream and
                // this block always agree on which bytes were taken.
                if (dib_q == 2'd3) begin
                    byte_d = 8'd0;
                    if (axiir && axiiv) begin
                        state_d = DATA;
                        shreg_d = axiid;
                        last_d  = axiilast;
                    end else begin
                        state_d    = IPG;
                        underrun_d = axiir;
                    end
                end
            end
            IPG: begin
                if (dib_q == 2'd3) begin
                    if (byte_q == IPG_LAST) begin
                        state_d = IDLE;
                    end else begin
                        byte_d = byte_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        axiov_d = (state_d == PREAMBLE) || (state_d == SFD) || (state_d == DATA);
        axiir_d = ((state_d == SFD) || (state_d == DATA)) && (dib_d == 2'd3) && !last_d;

        case (state_d)
            PREAMBLE: axiod_d = PREAMBLE_BYTE[1:0];
            SFD:      axiod_d = SFD_BYTE[2*dib_d +: 2];
            DATA:     axiod_d = shreg_d[1:0];
            default:  axiod_d = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_rmii_tx_serializer.sv
// Scoreboard bench for rmii_tx_serializer: the driver queues expected wire
// dibits, frame lengths and underrun flags; the monitor pops and compares as
// the DUT transmits, and also reassembles received bytes like an RMII receiver.
module tb_rmii_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] axiid = 8'd0;
    logic       axiiv = 1'b0;
    logic       axiilast = 1'b0;
    logic       axiir;
    logic [1:0] axiod;
    logic       axiov;
    logic       underrun;
    logic       busy;

    rmii_tx_serializer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axiid    (axiid),
        .axiiv    (axiiv),
        .axiilast (axiilast),
        .axiir    (axiir),
        .axiod    (axiod),
        .axiov    (axiov),
        .underrun (underrun),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0] exp_q[$];
    int         exp_len_q[$];
    bit         exp_ur_q[$];
    logic [7:0] rx_q[$];

    int         ir_cnt = 0;
    int         gap_cnt = 0;
    int         last_gap = 0;
    int         ipg_cnt = 0;
    int         frame_dib = 0;
    bit         prev_ov = 1'b0;
    bit         prev_busy = 1'b0;
    int         rx_phase = 0;
    int         rx_k = 0;
    logic [7:0] rx_sh = 8'd0;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares every wire cycle against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov   = 1'b0;
            prev_busy = 1'b0;
            frame_dib = 0;
            ipg_cnt   = 0;
            rx_phase  = 0;
        end else begin
            if (axiir) ir_cnt++;
            if (axiov) begin
                if (!prev_ov) begin
                    last_gap = gap_cnt;
                    rx_phase = 0;
                end
                frame_dib++;
                check("underrun_in_frame", underrun, 0);
                if (exp_q.size() == 0) check("extra_dibit", 1, 0);
                else check("dibit", axiod, exp_q.pop_front());
                if (rx_phase == 0) begin
                    if (axiod == 2'b11) begin
                        rx_phase = 1;
                        rx_k = 0;
                    end
                end else begin
                    rx_sh = {axiod, rx_sh[7:2]};
                    rx_k++;
                    if (rx_k == 4) begin
                        rx_q.push_back(rx_sh);
                        rx_k = 0;
                    end
                end
            end else begin
                check("idle_dibit", axiod, 0);
                check("ready_while_quiet", axiir, 0);
                if (prev_ov) begin
                    gap_cnt = 0;
                    if (exp_len_q.size() == 0) check("unexpected_frame", 1, 0);
                    else check("frame_len", frame_dib, exp_len_q.pop_front());
                    if (exp_ur_q.size() == 0) check("unexpected_frame_ur", 1, 0);
                    else check("underrun_pulse", underrun, int'(exp_ur_q.pop_front()));
                    frame_dib = 0;
                end else begin
                    check("underrun_quiet", underrun, 0);
                end
                gap_cnt++;
                if (busy) ipg_cnt++;
            end
            if (prev_busy && !busy) begin
                check("ipg_len", ipg_cnt, 48);
                ipg_cnt = 0;
            end
            prev_ov   = axiov;
            prev_busy = busy;
        end
    end

    // Queue the expected wire image of one frame.
    task automatic push_frame(input logic [7:0] data[$], input int n_cons, input bit ur);
        logic [7:0] b;
        for (int i = 0; i < 28; i++) exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        for (int i = 0; i < n_cons; i++) begin
            b = data[i];
            for (int k = 0; k < 4; k++) exp_q.push_back(2'((b >> (2 * k)) & 8'h03));
        end
        exp_len_q.push_back(4 * (8 + n_cons));
        exp_ur_q.push_back(ur);
    endtask

    // Drive one frame; n_give < size truncates it. hold_next keeps axiiv high
    // afterwards with next_b as a single-byte follow-on frame.
    task automatic send_frame(input logic [7:0] data[$], input int n_give, input bit chk_start,
                              input bit hold_next, input logic [7:0] next_b, output int n_ready);
        int idx;
        int budget;
        bit ur;
        @(posedge clk);
        #1;
        ur = (n_give < data.size());
        push_frame(data, ur ? n_give : data.size(), ur);
        ir_cnt   = 0;
        axiiv    = 1'b1;
        axiid    = data[0];
        axiilast = (data.size() == 1);
        if (chk_start) begin
            @(negedge clk);
            check("start_not_early", axiov, 0);
            @(negedge clk);
            check("start_latency", axiov, 1);
        end
        if (n_give == 0) begin
            @(posedge clk);
            #1;
            axiiv    = 1'b0;
            axiilast = 1'b0;
        end
        idx = 0;
        budget = 0;
        while (idx < n_give) begin
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                check("handshake_timeout", 0, 1);
                break;
            end
            if (axiir) begin
                @(posedge clk);
                #1;
                idx++;
                budget = 0;
                if (idx < n_give) begin
                    axiid    = data[idx];
                    axiilast = (idx == data.size() - 1);
                end else if (hold_next) begin
                    axiid    = next_b;
                    axiilast = 1'b1;
                end else begin
                    axiiv    = 1'b0;
                    axiilast = 1'b0;
                end
            end
        end
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (busy && budget < 5000);
        if (budget >= 5000) check("idle_timeout", 0, 1);
        n_ready = ir_cnt;
    endtask

    logic [7:0] d[$];
    int         nr;

    initial begin
        #35;
        check("rst_axiov", axiov, 0);
        check("rst_axiod", axiod, 0);
        check("rst_axiir", axiir, 0);
        check("rst_underrun", underrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single byte 0xA3 with last.
        d = '{8'hA3};
        send_frame(d, 1, 1'b1, 1'b0, 8'h00, nr);
        check("t1_ready_count", nr, 1);

        // Three back-to-back bytes.
        d = '{8'h0F, 8'hF0, 8'h5A};
        rx_q.delete();
        send_frame(d, 3, 1'b1, 1'b0, 8'h00, nr);
        check("t2_ready_count", nr, 3);
        check("t2_rx_count", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) check("t2_rx_byte", rx_q[i], d[i]);

        // 0x12 then nothing at the next fetch: underrun.
        d = '{8'h12, 8'h34};
        send_frame(d, 1, 1'b1, 1'b0, 8'h00, nr);
        check("t3_ready_count", nr, 2);

        // Underrun at the SFD fetch point: frame ends after SFD.
        d = '{8'h99};
        send_frame(d, 0, 1'b1, 1'b0, 8'h00, nr);
        check("t3b_ready_count", nr, 1);

        // Reset during preamble, then restart with no gap.
        @(posedge clk);
        #1;
        d = '{8'h77};
        push_frame(d, 1, 1'b0);
        axiiv = 1'b1;
        axiid = 8'h77;
        axiilast = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 9; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        axiiv = 1'b0;
        axiilast = 1'b0;
        #1;
        check("t4_axiov_async", axiov, 0);
        check("t4_busy_async", busy, 0);
        check("t4_axiod_async", axiod, 0);
        exp_q.delete();
        exp_len_q.delete();
        exp_ur_q.delete();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        d = '{8'hC6};
        send_frame(d, 1, 1'b1, 1'b0, 8'h00, nr);
        check("t4_ready_count", nr, 1);

        // axiiv held through IPG: follow-on frame must wait for IDLE.
        d = '{8'h3C};
        send_frame(d, 1, 1'b1, 1'b1, 8'h81, nr);
        d = '{8'h81};
        send_frame(d, 1, 1'b0, 1'b0, 8'h00, nr);
        check("t5_gap_cycles", last_gap, 49);
        check("t5_ready_count", nr, 1);

        // Full byte range through the receive reassembly model.
        d.delete();
        for (int i = 0; i < 256; i++) d.push_back(8'(i));
        rx_q.delete();
        send_frame(d, 256, 1'b1, 1'b0, 8'h00, nr);
        check("t6_ready_count", nr, 256);
        check("t6_rx_count", rx_q.size(), 256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++) check("t6_rx_byte", rx_q[i], i);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
